mod_n_counter_sched: RTL and testbench
======================================

# mod_n_counter_sched

Round-robin scheduler that shares one mod-N counting datapath between NUM_REQ requesters. Each requester asks for a run of `run_len` consecutive counter values starting at its own `start_val`. The block arbitrates among requesters, loads the counter, steps it with wrap at N-1, and signals completion. It sits between the per-channel sequencers and the single shared counter resource.

## Interface
- NUM_REQ, 4: number of requesters (2..16).
- N, 256: counter modulus; requires 2 <= N and N-1 representable in WIDTH bits.
- WIDTH, 32: counter value width.
- LEN_W, 16: run-length width.

- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- req  in  NUM_REQ  per-requester request level; held high until `done` or until the requester withdraws.
- start_val  in  NUM_REQ*WIDTH  start value of requester i at [i*WIDTH +: WIDTH].
- run_len  in  NUM_REQ*LEN_W  number of values requester i wants, at [i*LEN_W +: LEN_W].
- gnt  out  NUM_REQ  one-hot grant, registered.
- busy  out  1  high in any state other than IDLE.
- cnt_out  out  WIDTH  current counter value.
- cnt_valid  out  1  cnt_out is a value belonging to the granted run.
- wrap  out  1  single-cycle pulse on the cycle where cnt_out is 0 after stepping from N-1.
- done  out  NUM_REQ  single-cycle pulse to the finished requester.

## Operation
- The FSM has three states: IDLE, RUN and DONE. A round-robin pointer `last` (log2 NUM_REQ bits) records the last granted index.
- Reset values: state=IDLE, gnt=0, busy=0, cnt_out=0, cnt_valid=0, wrap=0, done=0, and `last`=NUM_REQ-1, so index 0 wins first.
- IDLE:
  - If any req bit is high, pick the first set bit searching from last+1 upward and wrapping. Set gnt to that bit and set last to that index.
  - Latch the chosen start_val into cnt_out. If start_val >= N, load 0 instead.
  - Latch the chosen run_len into the internal `remaining` register.
  - If run_len == 0, go to DONE and keep cnt_valid=0. Otherwise go to RUN with cnt_valid=1.
- RUN: on each cycle the FSM does all of the following:
  - Step cnt_out to (cnt_out==N-1) ? 0 : cnt_out+1.
  - Decrement `remaining`.
  - Set wrap=1 on the next cycle if the step was N-1 to 0.
  - When `remaining`==1, do not step. Instead go to DONE and set cnt_valid=0; cnt_out holds its last value.
- Withdrawal: if req[granted] is low in RUN, go directly to IDLE with gnt=0, cnt_valid=0 and no done pulse. Withdrawal has priority over the `remaining`==1 completion.
- DONE: done[granted]=1 for exactly this cycle and gnt is still held. On the next cycle go to IDLE with gnt=0 and done=0.
- Requests arriving while busy are not granted until IDLE. Non-granted req bits are ignored outside IDLE.
- A requester whose req is still high in IDLE after its own done is re-arbitrated normally. Because of the pointer, other pending requesters win first.
- Width rules:
  - cnt_out never exceeds N-1.
  - `remaining` is LEN_W bits and never underflows.
  - A run of run_len = 2^LEN_W-1 is legal.

## Timing
- Grant latency: req sampled high in IDLE at edge k gives gnt, cnt_out=start, cnt_valid=1 after edge k. There is 1 cycle from req to first value.
- cnt_valid is high for exactly run_len consecutive cycles, showing start, start+1, ... mod N.
- done pulses in the cycle immediately after the last valid value. gnt falls one cycle later.
- Job occupancy is run_len+2 cycles (RUN, DONE, IDLE). Minimum spacing between two grants is run_len+2 edges.
- A run_len==0 job occupies 2 cycles: gnt and done together for 1 cycle, then IDLE.
- wrap coincides with the cnt_out==0 cycle that follows N-1. It never fires on the load cycle, even if start_val is 0.
- Reset is asynchronous: asserting rst mid-RUN forces all reset values immediately. Operation resumes from IDLE on the first edge after rst deasserts.

## Test plan
- Basic wrap: N=256, req[0]=1, start_val0=250, run_len0=10. Requires:
  - cnt_out = 250..255, 0..3 with cnt_valid high for 10 cycles.
  - wrap high only on the cnt_out=0 cycle.
  - done[0] on the cycle after the value 3, then gnt=0.
- Round-robin: req[0] and req[2] held high, each with run_len=3. Requires grant order 0, 2, 0, 2 and a 5-cycle period per job. Adding req[1] mid-run makes the order 0, 1, 2 from the next arbitration.
- Clamp and zero length:
  - start_val1=300 with N=256: first cnt_out=0.
  - run_len=0: gnt and done[i] high together for 1 cycle, cnt_valid never high.
- Withdrawal: drop req[3] in the 4th RUN cycle of a run_len=8 job. Requires return to IDLE the next cycle, no done[3] pulse, gnt=0 and cnt_valid=0.
- Reset mid-run: assert rst asynchronously between edges during RUN. Requires all outputs to reach reset values before the next edge. After release, req[1] and req[0] pending gives the first grant to index 0.
- Edge modulus: N=2, start_val=1, run_len=4. Requires cnt_out = 1, 0, 1, 0 with wrap on both 0 cycles.

Source files
------------

// File: rtl/mod_n_counter_sched.sv
// mod_n_counter_sched
// Round-robin scheduler in front of one shared mod-N counter. A granted
// requester receives run_len consecutive counter values starting at its own
// start value. The counter wraps from N-1 to 0 and flags that step with a
// one-cycle wrap pulse. The block raises done when the run completes, or it
// drops the grant silently if the requester withdraws its request.

module mod_n_counter_sched #(
  parameter int NUM_REQ = 4,
  parameter int N       = 256,
  parameter int WIDTH   = 32,
  parameter int LEN_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   start_val,
  input  logic [NUM_REQ*LEN_W-1:0]   run_len,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic [WIDTH-1:0]           cnt_out,
  output logic                       cnt_valid,
  output logic                       wrap,
  output logic [NUM_REQ-1:0]         done
);

  localparam int                 IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [WIDTH-1:0]   CNT_MAX   = WIDTH'(N - 1);
  localparam logic [IDX_W-1:0]   LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   last_r;       // last granted index (round-robin pointer)
  logic [IDX_W-1:0]   cur_r;        // index of the requester owning the counter
  logic [LEN_W-1:0]   remaining_r;  // values still owed, including the one on cnt_out

  logic               pick_valid_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [IDX_W-1:0]   cand_s;
  logic               hit_s;
  logic [WIDTH-1:0]   pick_start_s;
  logic [LEN_W-1:0]   pick_len_s;
  logic [WIDTH-1:0]   load_val_s;
  logic [WIDTH-1:0]   step_val_s;
  logic               cur_req_s;
  logic               last_step_s;

  // Index reached by moving 'off' positions past 'base', wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return IDX_W'(sum % NUM_REQ);
  endfunction

  // One-hot vector with only bit 'idx' set.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin search: first requesting index after last_r, wrapping around.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    hit_s        = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_s       = rr_idx(last_r, off);
      hit_s        = req[cand_s] & ~pick_valid_s;
      pick_idx_s   = hit_s ? cand_s : pick_idx_s;
      pick_valid_s = pick_valid_s | hit_s;
    end
  end

  // Mux out the start value and run length of the requester being picked.
  always_comb begin
    pick_start_s = '0;
    pick_len_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_start_s = (pick_idx_s == IDX_W'(i)) ? start_val[i*WIDTH +: WIDTH] : pick_start_s;
      pick_len_s   = (pick_idx_s == IDX_W'(i)) ? run_len[i*LEN_W +: LEN_W]   : pick_len_s;
    end
  end

  // Counter datapath helpers: clamp out-of-range loads to 0; step with wrap at N-1.
  always_comb begin
    load_val_s  = '0;
    step_val_s  = '0;
    cur_req_s   = req[cur_r];
    last_step_s = (cnt_out == CNT_MAX);
    if (pick_start_s > CNT_MAX) begin
      load_val_s = '0;
    end else begin
      load_val_s = pick_start_s;
    end
    if (last_step_s) begin
      step_val_s = '0;
    end else begin
      step_val_s = cnt_out + WIDTH'(1);
    end
  end

  // Scheduler FSM: arbitration, counter load/step, completion and withdrawal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      last_r      <= LAST_INIT;
      cur_r       <= '0;
      remaining_r <= '0;
      gnt         <= '0;
      busy        <= 1'b0;
      cnt_out     <= '0;
      cnt_valid   <= 1'b0;
      wrap        <= 1'b0;
      done        <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wrap <= 1'b0;
          if (pick_valid_s) begin
            gnt         <= onehot(pick_idx_s);
            last_r      <= pick_idx_s;
            cur_r       <= pick_idx_s;
            cnt_out     <= load_val_s;
            remaining_r <= pick_len_s;
            busy        <= 1'b1;
            if (pick_len_s == '0) begin
              // Empty job: grant and done show up together for one cycle.
              state_r   <= ST_DONE;
              cnt_valid <= 1'b0;
              done      <= onehot(pick_idx_s);
            end else begin
              state_r   <= ST_RUN;
              cnt_valid <= 1'b1;
              done      <= '0;
            end
          end else begin
            state_r   <= ST_IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            cnt_valid <= 1'b0;
            done      <= '0;
          end
        end

        ST_RUN: begin
          if (!cur_req_s) begin
            // Withdrawal wins over completion: drop everything, no done pulse.
            state_r   <= ST_IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            cnt_valid <= 1'b0;
            wrap      <= 1'b0;
            done      <= '0;
          end else if (remaining_r <= LEN_ONE) begin
            // Last value already shown: hold cnt_out and report completion.
            state_r   <= ST_DONE;
            cnt_valid <= 1'b0;
            wrap      <= 1'b0;
            done      <= onehot(cur_r);
          end else begin
            state_r     <= ST_RUN;
            cnt_out     <= step_val_s;
            remaining_r <= remaining_r - LEN_ONE;
            wrap        <= last_step_s;
            done        <= '0;
          end
        end

        ST_DONE: begin
          state_r   <= ST_IDLE;
          gnt       <= '0;
          busy      <= 1'b0;
          cnt_valid <= 1'b0;
          wrap      <= 1'b0;
          done      <= '0;
        end

        default: begin
          // Unreachable encoding: recover to a quiet IDLE.
          state_r   <= ST_IDLE;
          gnt       <= '0;
          busy      <= 1'b0;
          cnt_valid <= 1'b0;
          wrap      <= 1'b0;
          done      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_n_counter_sched.sv
// Directed bench for mod_n_counter_sched: an N=256 instance for the main
// scenarios and an N=2 instance for the smallest modulus.

module tb_mod_n_counter_sched;

  logic          clk;
  logic          rst;

  logic [3:0]    req;
  logic [127:0]  start_val;
  logic [63:0]   run_len;
  logic [3:0]    gnt;
  logic          busy;
  logic [31:0]   cnt_out;
  logic          cnt_valid;
  logic          wrap;
  logic [3:0]    done;

  logic [3:0]    req_b;
  logic [127:0]  start_val_b;
  logic [63:0]   run_len_b;
  logic [3:0]    gnt_b;
  logic          busy_b;
  logic [31:0]   cnt_out_b;
  logic          cnt_valid_b;
  logic          wrap_b;
  logic [3:0]    done_b;

  int vectors;
  int miscompares;

  mod_n_counter_sched #(.NUM_REQ(4), .N(256), .WIDTH(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .start_val(start_val), .run_len(run_len),
    .gnt(gnt), .busy(busy), .cnt_out(cnt_out), .cnt_valid(cnt_valid),
    .wrap(wrap), .done(done)
  );

  mod_n_counter_sched #(.NUM_REQ(4), .N(2), .WIDTH(32), .LEN_W(16)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .start_val(start_val_b), .run_len(run_len_b),
    .gnt(gnt_b), .busy(busy_b), .cnt_out(cnt_out_b), .cnt_valid(cnt_valid_b),
    .wrap(wrap_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  // Called on the grant cycle; ends on the cycle after the following IDLE cycle.
  task automatic run_job(input int idx, input logic [31:0] start, input int len, input bit rel);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    chk("job_gnt", 32'(gnt), 32'(oh));
    chk("job_busy", 32'(busy), 32'd1);
    if (len > 0) begin
      chk("job_first_val", cnt_out, start);
      chk("job_first_valid", 32'(cnt_valid), 32'd1);
      repeat (len) tick();
      chk("job_done", 32'(done), 32'(oh));
      chk("job_gnt_held", 32'(gnt), 32'(oh));
      chk("job_valid_low", 32'(cnt_valid), 32'd0);
      chk("job_last_val", cnt_out, (start + 32'(len) - 32'd1) % 32'd256);
    end else begin
      chk("job0_done", 32'(done), 32'(oh));
      chk("job0_valid", 32'(cnt_valid), 32'd0);
    end
    if (rel) req[idx[1:0]] = 1'b0;
    tick();
    chk("job_idle_gnt", 32'(gnt), 32'd0);
    chk("job_idle_done", 32'(done), 32'd0);
    chk("job_idle_valid", 32'(cnt_valid), 32'd0);
    chk("job_idle_busy", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    req         = 4'b0000;
    start_val   = '0;
    run_len     = '0;
    req_b       = 4'b0000;
    start_val_b = '0;
    run_len_b   = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", cnt_out, 32'd0);
    chk("rst_valid", 32'(cnt_valid), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Basic wrap: 250..255, 0..3
    start_val[0*32 +: 32] = 32'd250;
    run_len[0*16 +: 16]   = 16'd10;
    req = 4'b0001;
    tick();
    chk("bw_gnt", 32'(gnt), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bw_cnt", cnt_out, 32'((250 + i) % 256));
      chk("bw_valid", 32'(cnt_valid), 32'd1);
      chk("bw_wrap", 32'(wrap), (i == 6) ? 32'd1 : 32'd0);
      chk("bw_done_low", 32'(done), 32'd0);
      tick();
    end
    chk("bw_done", 32'(done), 32'd1);
    chk("bw_gnt_held", 32'(gnt), 32'd1);
    chk("bw_valid_low", 32'(cnt_valid), 32'd0);
    chk("bw_cnt_hold", cnt_out, 32'd3);
    chk("bw_wrap_low", 32'(wrap), 32'd0);
    req = 4'b0000;
    tick();
    chk("bw_gnt_off", 32'(gnt), 32'd0);
    chk("bw_done_off", 32'(done), 32'd0);
    chk("bw_busy_off", 32'(busy), 32'd0);

    // Round-robin between 0 and 2, then 1 joins mid-run
    do_reset();
    start_val[0*32 +: 32] = 32'd10;
    start_val[2*32 +: 32] = 32'd20;
    start_val[1*32 +: 32] = 32'd30;
    run_len[0*16 +: 16]   = 16'd3;
    run_len[1*16 +: 16]   = 16'd3;
    run_len[2*16 +: 16]   = 16'd3;
    req = 4'b0101;
    tick();
    run_job(0, 32'd10, 3, 1'b0);
    run_job(2, 32'd20, 3, 1'b0);
    run_job(0, 32'd10, 3, 1'b0);
    run_job(2, 32'd20, 3, 1'b0);
    req[1] = 1'b1;
    run_job(0, 32'd10, 3, 1'b0);
    run_job(1, 32'd30, 3, 1'b0);
    run_job(2, 32'd20, 3, 1'b0);
    chk("rr_wrapback_gnt", 32'(gnt), 32'd1);
    req = 4'b0000;
    tick();
    chk("rr_withdraw_gnt", 32'(gnt), 32'd0);
    chk("rr_withdraw_done", 32'(done), 32'd0);

    // Clamp: start 300 with N=256 loads 0
    start_val[1*32 +: 32] = 32'd300;
    run_len[1*16 +: 16]   = 16'd2;
    req = 4'b0010;
    tick();
    run_job(1, 32'd0, 2, 1'b1);

    // Zero-length job
    start_val[3*32 +: 32] = 32'd5;
    run_len[3*16 +: 16]   = 16'd0;
    req = 4'b1000;
    tick();
    run_job(3, 32'd5, 0, 1'b1);

    // Withdrawal in the 4th RUN cycle of an 8-value job
    start_val[3*32 +: 32] = 32'd100;
    run_len[3*16 +: 16]   = 16'd8;
    req = 4'b1000;
    tick();
    chk("wd_gnt", 32'(gnt), 32'd8);
    chk("wd_first", cnt_out, 32'd100);
    repeat (3) tick();
    chk("wd_cnt4", cnt_out, 32'd103);
    chk("wd_valid4", 32'(cnt_valid), 32'd1);
    req = 4'b0000;
    tick();
    chk("wd_gnt_off", 32'(gnt), 32'd0);
    chk("wd_valid_off", 32'(cnt_valid), 32'd0);
    chk("wd_no_done", 32'(done), 32'd0);
    chk("wd_busy_off", 32'(busy), 32'd0);
    tick();
    chk("wd_no_done_late", 32'(done), 32'd0);

    // Asynchronous reset during RUN
    start_val[0*32 +: 32] = 32'd7;
    run_len[0*16 +: 16]   = 16'd8;
    req = 4'b0001;
    tick();
    chk("ar_gnt", 32'(gnt), 32'd1);
    tick();
    chk("ar_cnt", cnt_out, 32'd8);
    #2 rst = 1'b1;
    #1;
    chk("ar_rst_gnt", 32'(gnt), 32'd0);
    chk("ar_rst_busy", 32'(busy), 32'd0);
    chk("ar_rst_cnt", cnt_out, 32'd0);
    chk("ar_rst_valid", 32'(cnt_valid), 32'd0);
    chk("ar_rst_done", 32'(done), 32'd0);
    req = 4'b0011;
    #1 rst = 1'b0;
    tick();
    chk("ar_first_gnt", 32'(gnt), 32'd1);
    chk("ar_first_cnt", cnt_out, 32'd7);
    req = 4'b0000;
    tick();
    chk("ar_drop_gnt", 32'(gnt), 32'd0);

    // N=2 instance: 1, 0, 1, 0 with wrap on each 0
    start_val_b[0*32 +: 32] = 32'd1;
    run_len_b[0*16 +: 16]   = 16'd4;
    req_b = 4'b0001;
    tick();
    chk("n2_gnt", 32'(gnt_b), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("n2_cnt", cnt_out_b, 32'((i + 1) % 2));
      chk("n2_wrap", 32'(wrap_b), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("n2_valid", 32'(cnt_valid_b), 32'd1);
      tick();
    end
    chk("n2_done", 32'(done_b), 32'd1);
    chk("n2_wrap_low", 32'(wrap_b), 32'd0);
    req_b = 4'b0000;
    tick();
    chk("n2_idle_gnt", 32'(gnt_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
